// File: rtl/rc5_pkg.sv
// rc5_pkg: shared RC5 magic constants, FSM state encoding and derived-size helpers
package rc5_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, INIT_S, MIX_A, MIX_B, DONE} state_e;
  function automatic logic [63:0] rc5_p(input int w);
    return w == 16 ? 64'hB7E1 : w == 32 ? 64'hB7E1_5163 : 64'hB7E1_5162_8AED_2A6B;
  endfunction
  function automatic logic [63:0] rc5_q(input int w);
    return w == 16 ? 64'h9E37 : w == 32 ? 64'h9E37_79B9 : 64'h9E37_79B9_7F4A_7C15;
  endfunction
  function automatic int rc5_t(input int r);
    return 2 * (r + 1);
  endfunction
  function automatic int rc5_c(input int b, input int w);
    int u;
    u = w / 8;
    return b <= u ? 1 : (b + u - 1) / u;
  endfunction
  function automatic int rc5_n(input int t, input int c);
    return 3 * (t > c ? t : c);
  endfunction
  // index width able to count 0..n-1, never narrower than one bit
  function automatic int rc5_bits(input int n);
    return n <= 2 ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/rc5_rotl.sv
// rc5_rotl: combinational W-bit variable left rotate
module rc5_rotl #(
  parameter int W = 32,
  parameter int RW = $clog2(W)
) (
  input  logic [W-1:0]  x,
  input  logic [RW-1:0] amt,
  output logic [W-1:0]  y
);
  assign y = (x << amt) | (x >> (W - int'(amt)));
endmodule

// File: rtl/rc5_key_expand.sv
// rc5_key_expand: RC5 key schedule, expands iKey into the S table and serves two registered read ports
// Optional RC5_KEY_ZEROIZE_EN: clears S, L, A and B on every transition into IDLE.
module rc5_key_expand
  import rc5_pkg::*;
#(
  parameter int W = 32,
  parameter int R = 12,
  parameter int B = 16,
  localparam int T = rc5_t(R),
  localparam int T_LENGTH = $clog2(T)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                iStart,
  input  logic [8*B-1:0]      iKey,
  input  logic [T_LENGTH-1:0] iS_address1,
  input  logic [T_LENGTH-1:0] iS_address2,
  output logic [W-1:0]        oS_sub_i1,
  output logic [W-1:0]        oS_sub_i2,
  output logic                oDone
);
  localparam int U = W / 8;
  localparam int C = rc5_c(B, W);
  localparam int N = rc5_n(T, C);
  localparam int ROT_VALUE = $clog2(W);
  localparam int JW = rc5_bits(C);
  localparam int KW = rc5_bits(N);
  localparam int KPW = 8 * U * C;
  localparam logic [63:0] P64 = rc5_p(W);
  localparam logic [63:0] Q64 = rc5_q(W);
  localparam logic [W-1:0] P_W = P64[W-1:0];
  localparam logic [W-1:0] Q_W = Q64[W-1:0];
  state_e              state_q, state_d;
  logic [W-1:0]        s_q [T];
  logic [W-1:0]        s_d [T];
  logic [W-1:0]        l_q [C];
  logic [W-1:0]        l_d [C];
  logic [W-1:0]        a_q, a_d, b_q, b_d;
  logic [T_LENGTH-1:0] i_q, i_d;
  logic [JW-1:0]       j_q, j_d;
  logic [KW-1:0]       k_q, k_d;
  logic                done_q, done_d;
  logic [W-1:0]        rd1_q, rd1_d, rd2_q, rd2_d;
  logic [KPW-1:0]      key_pad;
  logic [W-1:0]        mix_a_sum, mix_a_val, ab_sum, mix_b_sum, mix_b_val;
  assign key_pad   = KPW'(iKey);
  assign mix_a_sum = s_q[i_q] + a_q + b_q;
  assign mix_a_val = {mix_a_sum[W-4:0], mix_a_sum[W-1:W-3]};
  assign ab_sum    = a_q + b_q;
  assign mix_b_sum = l_q[j_q] + ab_sum;
  rc5_rotl #(.W(W), .RW(ROT_VALUE)) u_rotl (
    .x  (mix_b_sum),
    .amt(ab_sum[ROT_VALUE-1:0]),
    .y  (mix_b_val)
  );
  assign oS_sub_i1 = rd1_q;
  assign oS_sub_i2 = rd2_q;
  assign oDone     = done_q;
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    l_d     = l_q;
    a_d     = a_q;
    b_d     = b_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    done_d  = 1'b0;
    rd1_d   = {1'b0, iS_address1} < (T_LENGTH + 1)'(T) ? s_q[iS_address1] : '0;
    rd2_d   = {1'b0, iS_address2} < (T_LENGTH + 1)'(T) ? s_q[iS_address2] : '0;
    if (!iStart) begin
      state_d = IDLE;
`ifdef RC5_KEY_ZEROIZE_EN
      if (state_q != IDLE) begin
        s_d = '{default: '0};
        l_d = '{default: '0};
        a_d = '0;
        b_d = '0;
      end
`endif
    end else begin
      case (state_q)
        IDLE: state_d = LOAD;
        LOAD: begin
          for (int w = 0; w < C; w++) l_d[w] = key_pad[w*W +: W];
          s_d[0]  = P_W;
          i_d     = T_LENGTH'(1);
          state_d = INIT_S;
        end
        INIT_S: begin
          s_d[i_q] = s_q[i_q - T_LENGTH'(1)] + Q_W;
          i_d      = i_q + T_LENGTH'(1);
          if (i_q == T_LENGTH'(T - 1)) begin
            a_d     = '0;
            b_d     = '0;
            i_d     = '0;
            j_d     = '0;
            k_d     = '0;
            state_d = MIX_A;
          end
        end
        MIX_A: begin
          s_d[i_q] = mix_a_val;
          a_d      = mix_a_val;
          state_d  = MIX_B;
        end
        // A here already holds the value written in MIX_A
        MIX_B: begin
          l_d[j_q] = mix_b_val;
          b_d      = mix_b_val;
          i_d      = i_q == T_LENGTH'(T - 1) ? '0 : i_q + T_LENGTH'(1);
          j_d      = j_q == JW'(C - 1) ? '0 : j_q + JW'(1);
          k_d      = k_q + KW'(1);
          state_d  = k_q == KW'(N - 1) ? DONE : MIX_A;
        end
        DONE: done_d = 1'b1;
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      s_q     <= '{default: '0};
      l_q     <= '{default: '0};
      a_q     <= '0;
      b_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      done_q  <= 1'b0;
      rd1_q   <= '0;
      rd2_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      l_q     <= l_d;
      a_q     <= a_d;
      b_q     <= b_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      done_q  <= done_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
    end
  end
endmodule
